uart_tx: RTL

//   UART serial transmitter; the transmit-side counterpart of the team's uart_rx.

---
 rtl/uart_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter paced by a 16x oversample tick
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);

  state_t            state;
  logic [4:0]        s_reg;
  logic [2:0]        n_reg;
  logic [DBIT-1:0]   b_reg;
  logic              par_reg;

  function automatic logic parity_of(input logic [DBIT-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  // tx_busy stays high through the tx_done_tick cycle, so IDLE only accepts
  // a new request once it has dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      par_reg      <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start && !tx_busy) begin
            b_reg   <= din[DBIT-1:0];
            par_reg <= parity_of(din[DBIT-1:0]);
            s_reg   <= '0;
            n_reg   <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end else begin
            tx_busy <= 1'b0;
          end
        end

        START: begin
          if (s_tick) begin
            if (s_reg == BIT_LAST) begin
              s_reg <= '0;
              tx    <= b_reg[0];
              state <= DATA;
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_reg == BIT_LAST) begin
              s_reg <= '0;
              b_reg <= b_reg >> 1;
              if (n_reg == DATA_LAST) begin
                if (PARITY != 0) begin
                  tx    <= par_reg;
                  state <= PAR;
                end else begin
                  tx    <= 1'b1;
                  state <= STOP;
                end
              end else begin
                n_reg <= n_reg + 3'd1;
                tx    <= b_reg[1];
              end
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        PAR: begin
          if (s_tick) begin
            if (s_reg == BIT_LAST) begin
              s_reg <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s_reg == STOP_LAST) begin
              s_reg        <= '0;
              tx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
